// File: rtl/grey_hist.sv
// grey_hist: 256-bin histogram of 8-bit grey pixels with a clear sweep,
// a forwarded read-modify-write update pipeline and a 2-cycle bin read port.
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   clr_i              clear request (frame start), restarts the sweep
//   init_i, data_i     pixel valid and pixel (grey in data_i[7:0])
//   rd_i, rd_addr_i    bin read request and bin index
//   rd_data_o          bin count, valid with rd_done_o, held otherwise
//   rd_done_o          one-cycle read strobe
//   busy_o             high while clearing
//   drop_o             pixels dropped since the last clear (saturating)
module grey_hist #(
    parameter int CNT_WIDTH  = 20,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  init_i,
    input  logic [23:0]           data_i,
    input  logic                  rd_i,
    input  logic [7:0]            rd_addr_i,
    output logic [CNT_WIDTH-1:0]  rd_data_o,
    output logic                  rd_done_o,
    output logic                  busy_o,
    output logic [DROP_WIDTH-1:0] drop_o
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [CNT_WIDTH-1:0]  CMAX = {CNT_WIDTH{1'b1}};
    localparam logic [DROP_WIDTH-1:0] DMAX = {DROP_WIDTH{1'b1}};

    state_t state, state_nx;
    logic [7:0] swp;

    logic [CNT_WIDTH-1:0] mem [256];
    logic [CNT_WIDTH-1:0] pix_q, rd_q;

    logic                 s1_v, s2_v, w_v, r1_v;
    logic [7:0]           s1_a, s2_a, w_a, r1_a;
    logic [CNT_WIDTH-1:0] s2_d, w_d;

    logic                 accept, rd_go, we;
    logic [7:0]           wa;
    logic [CNT_WIDTH-1:0] wd, pix_cur, pix_inc, rd_cur;

    logic unused_bits;
    assign unused_bits = ^data_i[23:8];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= CLEAR;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR: if (!clr_i && swp == 8'hFF) state_nx = RUN;
            RUN:   if (clr_i) state_nx = CLEAR;
            default: state_nx = CLEAR;
        endcase
    end

    // The update write is suppressed in the clr_i cycle so nothing
    // from the old frame lands once the sweep has been requested.
    always_comb begin
        busy_o = (state == CLEAR);
        accept = (state == RUN) && init_i && !clr_i;
        rd_go  = (state == RUN) && rd_i;
        we     = 1'b0;
        wa     = swp;
        wd     = '0;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (s2_v && !clr_i) begin
            we = 1'b1;
            wa = s2_a;
            wd = s2_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                swp <= '0;
        else if (clr_i)           swp <= '0;
        else if (state == CLEAR)  swp <= swp + 8'd1;
    end

    // Two synchronous read ports: one for updates, one for host reads.
    always_ff @(posedge clk_i) begin
        if (we) mem[wa] <= wd;
        pix_q <= mem[data_i[7:0]];
        rd_q  <= mem[rd_addr_i];
    end

    // Memory data misses the write in flight (s2) and the write that
    // landed on the same edge as the read (w); newest wins.
    always_comb begin
        if (s2_v && s2_a == s1_a)     pix_cur = s2_d;
        else if (w_v && w_a == s1_a)  pix_cur = w_d;
        else                          pix_cur = pix_q;
        pix_inc = (pix_cur == CMAX) ? pix_cur : pix_cur + 1'b1;
        if (s2_v && s2_a == r1_a)     rd_cur = s2_d;
        else if (w_v && w_a == r1_a)  rd_cur = w_d;
        else                          rd_cur = rd_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s2_v      <= 1'b0;
            s2_a      <= '0;
            s2_d      <= '0;
            w_v       <= 1'b0;
            w_a       <= '0;
            w_d       <= '0;
            r1_v      <= 1'b0;
            r1_a      <= '0;
            rd_done_o <= 1'b0;
            rd_data_o <= '0;
        end else begin
            s1_v      <= accept;
            s1_a      <= data_i[7:0];
            s2_v      <= s1_v && !clr_i;
            s2_a      <= s1_a;
            s2_d      <= pix_inc;
            w_v       <= s2_v && !clr_i;
            w_a       <= s2_a;
            w_d       <= s2_d;
            r1_v      <= rd_go;
            r1_a      <= rd_addr_i;
            rd_done_o <= r1_v;
            if (r1_v) rd_data_o <= rd_cur;
        end
    end

    // A pixel arriving with clr_i is the first drop of the new frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            drop_o <= '0;
        else if (clr_i)
            drop_o <= DROP_WIDTH'(init_i);
        else if (state == CLEAR && init_i && drop_o != DMAX)
            drop_o <= drop_o + 1'b1;
    end

endmodule

// File: tb/tb_grey_hist.sv
// tb_grey_hist: directed checks of grey_hist with 20-bit and 8-bit bins.
// Both instances share stimulus; inputs change on the falling edge.
module tb_grey_hist;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        init = 1'b0;
    logic [23:0] data = '0;
    logic        rd = 1'b0;
    logic [7:0]  rd_addr = '0;

    logic [19:0] rd_data20;
    logic [7:0]  rd_data8;
    logic        done20, done8, busy20, busy8;
    logic [15:0] drop20, drop8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grey_hist #(.CNT_WIDTH(20), .DROP_WIDTH(16)) u20 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .init_i(init),
        .data_i(data), .rd_i(rd), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data20), .rd_done_o(done20),
        .busy_o(busy20), .drop_o(drop20)
    );

    grey_hist #(.CNT_WIDTH(8), .DROP_WIDTH(16)) u8 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .init_i(init),
        .data_i(data), .rd_i(rd), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data8), .rd_done_o(done8),
        .busy_o(busy8), .drop_o(drop8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic i, input logic [7:0] p, input logic r,
                       input logic [7:0] a, input logic c);
        @(negedge clk);
        init    = i;
        data    = {3{p}};
        rd      = r;
        rd_addr = a;
        clr     = c;
    endtask

    task automatic pixels(input logic [7:0] p, input int n);
        for (int k = 0; k < n; k++) drv(1'b1, p, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic rd_bin(input logic [7:0] a, output logic d,
                          output logic [19:0] v20, output logic [7:0] v8);
        drv(1'b0, 8'd0, 1'b1, a, 1'b0);
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        d   = done20 & done8;
        v20 = rd_data20;
        v8  = rd_data8;
    endtask

    task automatic read_all_zero(input string tag);
        int bad = 0;
        for (int i = 0; i < 258; i++) begin
            drv(1'b0, 8'd0, i < 256, 8'(i), 1'b0);
            if (i >= 2)
                if (!done20 || !done8 || rd_data20 != 0 || rd_data8 != 0)
                    bad++;
        end
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk(tag, bad, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy20 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, busy20, 0);
    endtask

    initial begin
        logic        d, seen;
        logic [19:0] v20;
        logic [7:0]  v8;
        int          cnt;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy20, 1);
        chk("rst_done", done20, 0);
        chk("rst_data", rd_data20, 0);
        chk("rst_drop", drop20, 0);

        // release reset with a read held high: ignored while clearing
        @(negedge clk);
        rst     = 1'b0;
        rd      = 1'b1;
        rd_addr = 8'd0;
        cnt  = 0;
        seen = 1'b0;
        while (busy20 && cnt < 1000) begin
            cnt++;
            if (done20 || done8) seen = 1'b1;
            @(negedge clk);
        end
        rd = 1'b0;
        chk("busy_len", cnt, 256);
        chk("busy8_low", busy8, 0);
        repeat (3) begin
            drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
            if (done20 || done8) seen = 1'b1;
        end
        chk("rd_in_clear", seen, 0);
        read_all_zero("init_zero");

        pixels(8'h5A, 1000);
        rd_bin(8'h5A, d, v20, v8);
        chk("5a_done", d, 1);
        chk("5a_cnt20", v20, 1000);
        chk("5a_cnt8", v8, 255);
        rd_bin(8'h5B, d, v20, v8);
        chk("5b_cnt20", v20, 0);

        // read data is held while no read completes
        repeat (2) drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("hold_done", done20, 0);
        chk("hold_data", rd_data20, 0);

        pixels(8'd3, 2);
        pixels(8'd7, 1);
        pixels(8'd3, 1);
        pixels(8'd7, 2);
        rd_bin(8'd3, d, v20, v8);
        chk("alt_bin3", v20, 3);
        rd_bin(8'd7, d, v20, v8);
        chk("alt_bin7", v20, 3);

        pixels(8'h10, 300);
        rd_bin(8'h10, d, v20, v8);
        chk("sat_cnt8", v8, 255);
        chk("sat_cnt20", v20, 300);

        // read of bin 9 in the same cycle as a pixel 9, then back-to-back
        pixels(8'd9, 4);
        drv(1'b1, 8'd9, 1'b1, 8'd9, 1'b0);
        drv(1'b0, 8'd0, 1'b1, 8'd9, 1'b0);
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("b9_done1", done20, 1);
        chk("b9_first", rd_data20, 4);
        @(negedge clk);
        chk("b9_done2", done20, 1);
        chk("b9_second", rd_data20, 5);
        @(negedge clk);
        chk("b9_strobe", done20, 0);
        chk("b9_hold", rd_data20, 5);

        // clear mid-stream: the pixel with clr counts as a drop
        pixels(8'h20, 20);
        drv(1'b1, 8'h20, 1'b0, 8'd0, 1'b1);
        drv(1'b1, 8'h20, 1'b0, 8'd0, 1'b0);
        chk("drop_first", drop20, 1);
        chk("clr_busy", busy20, 1);
        pixels(8'h20, 8);
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("drop_ten", drop20, 10);
        chk("drop8_ten", drop8, 10);
        wait_idle("clr_done");
        read_all_zero("clr_zero");
        chk("drop_keep", drop20, 10);

        // clr during CLEAR restarts the full sweep
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        repeat (100) drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        drv(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("drop_zero", drop20, 0);
        cnt = 0;
        while (busy20 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("restart_len", cnt, 256);
        rd_bin(8'h10, d, v20, v8);
        chk("post_clr_10", v20, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
